// File: rtl/stereo_disparity_engine_if.sv
// Frame-buffer read bus and disparity result stream of the stereo block matcher.
// The engine drives the master side; memories and the result store sit on the slave side.
interface stereo_disparity_engine_if #(
    parameter int IMG_W      = 240,
    parameter int IMG_H      = 320,
    parameter int BLOCK_SIZE = 6,
    parameter int MAX_DISP   = 63,
    parameter int PIX_W      = 8
);
    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int D_W    = $clog2(MAX_DISP + 1);
    localparam int COST_W = $clog2(longint'(BLOCK_SIZE) * BLOCK_SIZE *
                                   ((longint'(1) << PIX_W) - 1) *
                                   ((longint'(1) << PIX_W) - 1) + 1);

    logic                          rd_en;
    logic [Y_W-1:0]                rd_y;
    logic [X_W-1:0]                rd_left_x;
    logic [X_W-1:0]                rd_right_x;
    logic [BLOCK_SIZE*PIX_W-1:0]   rd_left_data;
    logic [BLOCK_SIZE*PIX_W-1:0]   rd_right_data;

    logic                          disp_valid;
    logic                          disp_ready;
    logic [D_W-1:0]                disp_data;
    logic [X_W-1:0]                disp_x;
    logic [Y_W-1:0]                disp_y;
    logic [COST_W-1:0]             disp_cost;

    modport master (
        output rd_en, rd_y, rd_left_x, rd_right_x,
        input  rd_left_data, rd_right_data,
        output disp_valid, disp_data, disp_x, disp_y, disp_cost,
        input  disp_ready
    );

    modport slave (
        input  rd_en, rd_y, rd_left_x, rd_right_x,
        output rd_left_data, rd_right_data,
        input  disp_valid, disp_data, disp_x, disp_y, disp_cost,
        output disp_ready
    );
endinterface

// File: rtl/stereo_disparity_engine.sv
// Block-matching disparity engine: for each left block, searches right-image offsets
// 0..min(MAX_DISP,x) with SSD or SAD cost and streams the best match out.
module stereo_disparity_engine #(
    parameter int IMG_W       = 240,
    parameter int IMG_H       = 320,
    parameter int BLOCK_SIZE  = 6,
    parameter int MAX_DISP    = 63,
    parameter int PIX_W       = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start_in,
    input  logic mode_in,
    output logic busy,
    output logic done,
    stereo_disparity_engine_if.master bus
);
    localparam int X_W    = $clog2(IMG_W);
    localparam int Y_W    = $clog2(IMG_H);
    localparam int D_W    = $clog2(MAX_DISP + 1);
    localparam int COST_W = $clog2(longint'(BLOCK_SIZE) * BLOCK_SIZE *
                                   ((longint'(1) << PIX_W) - 1) *
                                   ((longint'(1) << PIX_W) - 1) + 1);
    localparam int CNT_MAX = (BLOCK_SIZE > MEM_LATENCY) ? BLOCK_SIZE : MEM_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_COMPARE, S_EMIT, S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic                   mode_sad;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [D_W-1:0]         d, d_max, best_d;
    logic [CNT_W-1:0]       cnt;
    logic [COST_W-1:0]      acc, best_cost, row_cost;
    logic [MEM_LATENCY-1:0] vld_pipe;
    logic                   fetching, fetch_last, drain_last;
    logic                   take, more_cand, x_last, last_pos;
    logic [2*PIX_W-1:0]     pix_cost [BLOCK_SIZE];

    assign fetching   = (state == S_FETCH);
    assign fetch_last = (cnt == CNT_W'(BLOCK_SIZE - 1));
    assign drain_last = (cnt == CNT_W'(MEM_LATENCY - 1));
    assign d_max      = (int'(x) < MAX_DISP) ? D_W'(x) : D_W'(MAX_DISP);
    assign take       = (d == '0) || (acc < best_cost);
    assign more_cand  = (d < d_max);
    assign x_last     = (x == X_W'(IMG_W - BLOCK_SIZE));
    assign last_pos   = x_last && (y == Y_W'(IMG_H - BLOCK_SIZE));

    assign bus.rd_en      = fetching;
    assign bus.rd_y       = fetching ? y + Y_W'(cnt) : '0;
    assign bus.rd_left_x  = fetching ? x : '0;
    assign bus.rd_right_x = fetching ? x - X_W'(d) : '0;
    assign busy           = (state != S_IDLE) && (state != S_DONE);
    assign done           = (state == S_DONE);

    // Per-pixel cost of the returning row; the difference is taken as a magnitude first.
    for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_pix
        logic [PIX_W-1:0]   lp, rp, ad;
        logic [2*PIX_W-1:0] adw;
        assign lp          = bus.rd_left_data[i*PIX_W +: PIX_W];
        assign rp          = bus.rd_right_data[i*PIX_W +: PIX_W];
        assign ad          = (lp > rp) ? lp - rp : rp - lp;
        assign adw         = {{PIX_W{1'b0}}, ad};
        assign pix_cost[i] = mode_sad ? adw : adw * adw;
    end

    always_comb begin
        row_cost = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            row_cost = row_cost + COST_W'(pix_cost[i]);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: next state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_in) state_nxt = S_FETCH;
            S_FETCH:   if (fetch_last) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_last) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = more_cand ? S_FETCH : S_EMIT;
            S_EMIT:    if (bus.disp_ready) state_nxt = last_pos ? S_DONE : S_FETCH;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mode_sad       <= 1'b0;
            x              <= '0;
            y              <= '0;
            d              <= '0;
            cnt            <= '0;
            acc            <= '0;
            best_cost      <= '0;
            best_d         <= '0;
            vld_pipe       <= '0;
            bus.disp_valid <= 1'b0;
            bus.disp_data  <= '0;
            bus.disp_x     <= '0;
            bus.disp_y     <= '0;
            bus.disp_cost  <= '0;
        end else begin
            // Row data lands MEM_LATENCY cycles after its strobe; the shift tracks which cycles carry it.
            vld_pipe <= MEM_LATENCY'({vld_pipe, fetching});
            if (vld_pipe[MEM_LATENCY-1]) acc <= acc + row_cost;

            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        mode_sad <= mode_in;
                        x        <= '0;
                        y        <= '0;
                        d        <= '0;
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                S_FETCH: cnt <= fetch_last ? '0 : cnt + CNT_W'(1);
                S_DRAIN: cnt <= drain_last ? '0 : cnt + CNT_W'(1);
                S_COMPARE: begin
                    if (take) begin
                        best_cost <= acc;
                        best_d    <= d;
                    end
                    if (more_cand) begin
                        d   <= d + D_W'(1);
                        acc <= '0;
                    end else begin
                        bus.disp_valid <= 1'b1;
                        bus.disp_data  <= take ? d : best_d;
                        bus.disp_cost  <= take ? acc : best_cost;
                        bus.disp_x     <= x;
                        bus.disp_y     <= y;
                    end
                end
                S_EMIT: begin
                    if (bus.disp_ready) begin
                        bus.disp_valid <= 1'b0;
                        if (!last_pos) begin
                            if (x_last) begin
                                x <= '0;
                                y <= y + Y_W'(1);
                            end else begin
                                x <= x + X_W'(1);
                            end
                            d   <= '0;
                            acc <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_stereo_disparity_engine.sv
// Self-checking bench for stereo_disparity_engine: latency-modelled frame memories and a
// brute-force block-matching reference that predicts every streamed result.
module tb_stereo_disparity_engine;
    localparam int IMG_W    = 16;
    localparam int IMG_H    = 8;
    localparam int BS       = 2;
    localparam int MAX_DISP = 4;
    localparam int PIX_W    = 8;
    localparam int LAT      = 2;
    localparam int X_W      = 4;
    localparam int Y_W      = 3;
    localparam int D_W      = 3;
    localparam int COST_W   = 18;
    localparam int N_POS    = (IMG_W - BS + 1) * (IMG_H - BS + 1);

    typedef struct {
        int x;
        int y;
        int d;
        int cost;
    } res_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic start_in = 1'b0;
    logic mode_in = 1'b0;
    logic busy, done;

    int n_vec = 0;
    int n_err = 0;

    stereo_disparity_engine_if #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(BS), .MAX_DISP(MAX_DISP), .PIX_W(PIX_W)
    ) bus ();

    stereo_disparity_engine #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(BS), .MAX_DISP(MAX_DISP),
        .PIX_W(PIX_W), .MEM_LATENCY(LAT)
    ) dut (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .start_in(start_in),
        .mode_in (mode_in),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    int   limg [IMG_H][IMG_W];
    int   rimg [IMG_H][IMG_W];
    res_t exp_q[$];

    // Frame memories: requests travel through an LAT-deep pipe, data appears LAT cycles after rd_en.
    logic pv  [LAT];
    int   py  [LAT];
    int   plx [LAT];
    int   prx [LAT];

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0]  <= bus.rd_en;
            py[0]  <= int'(bus.rd_y);
            plx[0] <= int'(bus.rd_left_x);
            prx[0] <= int'(bus.rd_right_x);
            for (int i = 1; i < LAT; i++) begin
                pv[i]  <= pv[i-1];
                py[i]  <= py[i-1];
                plx[i] <= plx[i-1];
                prx[i] <= prx[i-1];
            end
        end
    end

    always_comb begin
        bus.rd_left_data  = '0;
        bus.rd_right_data = '0;
        if (pv[LAT-1]) begin
            for (int i = 0; i < BS; i++) begin
                bus.rd_left_data[i*PIX_W +: PIX_W]  = PIX_W'(limg[py[LAT-1]][plx[LAT-1] + i]);
                bus.rd_right_data[i*PIX_W +: PIX_W] = PIX_W'(rimg[py[LAT-1]][prx[LAT-1] + i]);
            end
        end
    end

    // Counts read bursts; one burst per evaluated candidate.
    int   bursts = 0;
    logic rd_en_q;
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_en_q <= 1'b0;
        end else begin
            rd_en_q <= bus.rd_en;
            if (bus.rd_en && !rd_en_q) bursts <= bursts + 1;
        end
    end

    function automatic int pcost(input int a, input int b, input bit sad);
        int df;
        df = (a > b) ? a - b : b - a;
        return sad ? df : df * df;
    endfunction

    task automatic build_expected(input bit sad);
        res_t r;
        exp_q.delete();
        for (int y = 0; y <= IMG_H - BS; y++) begin
            for (int x = 0; x <= IMG_W - BS; x++) begin
                int best, bd, dmax;
                best = 0;
                bd   = 0;
                dmax = (x < MAX_DISP) ? x : MAX_DISP;
                for (int d = 0; d <= dmax; d++) begin
                    int c;
                    c = 0;
                    for (int rr = 0; rr < BS; rr++)
                        for (int cc = 0; cc < BS; cc++)
                            c += pcost(limg[y+rr][x+cc], rimg[y+rr][x-d+cc], sad);
                    if (d == 0 || c < best) begin
                        best = c;
                        bd   = d;
                    end
                end
                r.x = x; r.y = y; r.d = bd; r.cost = best;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic run_frame(input bit sad, input bit bp, output int first_cost);
        res_t           e;
        int             got, dones, post, last_bursts, nb, nb_exp;
        bit             finished;
        logic [X_W-1:0] sx;
        logic [Y_W-1:0] sy;
        logic [D_W-1:0] sd;
        logic [COST_W-1:0] sc;
        got = 0; dones = 0; post = 0; finished = 0; first_cost = -1;
        build_expected(sad);
        last_bursts = bursts;
        @(negedge clk_in);
        start_in = 1'b1;
        mode_in  = sad;
        @(negedge clk_in);
        start_in = 1'b0;
        mode_in  = ~sad;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk_in);
            if (bus.disp_valid === 1'b1) begin
                if (bp && got == 0) begin
                    bus.disp_ready = 1'b0;
                    sx = bus.disp_x; sy = bus.disp_y; sd = bus.disp_data; sc = bus.disp_cost;
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk_in);
                        start_in = (k == 3);
                        mode_in  = (k == 3) ? ~sad : mode_in;
                        n_vec++;
                        if ({bus.disp_valid, bus.rd_en, bus.disp_x, bus.disp_y, bus.disp_data, bus.disp_cost}
                            !== {1'b1, 1'b0, sx, sy, sd, sc}) begin
                            n_err++;
                            $display("FAIL stall_hold cyc %0d: got v=%b rd=%b x=%0d y=%0d d=%0d c=%0d expected v=1 rd=0 x=%0d y=%0d d=%0d c=%0d",
                                     k, bus.disp_valid, bus.rd_en, bus.disp_x, bus.disp_y, bus.disp_data,
                                     bus.disp_cost, sx, sy, sd, sc);
                        end
                    end
                    start_in = 1'b0;
                    bus.disp_ready = 1'b1;
                end
                if (got == 0) first_cost = int'(bus.disp_cost);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_result: got (%0d,%0d) expected no more results", bus.disp_x, bus.disp_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.disp_x, bus.disp_y, bus.disp_data, bus.disp_cost} !==
                        {X_W'(e.x), Y_W'(e.y), D_W'(e.d), COST_W'(e.cost)}) begin
                        n_err++;
                        $display("FAIL result #%0d: got x=%0d y=%0d d=%0d cost=%0d expected x=%0d y=%0d d=%0d cost=%0d",
                                 got, bus.disp_x, bus.disp_y, bus.disp_data, bus.disp_cost, e.x, e.y, e.d, e.cost);
                    end
                    nb     = bursts - last_bursts;
                    nb_exp = ((e.x < MAX_DISP) ? e.x : MAX_DISP) + 1;
                    n_vec++;
                    if (nb !== nb_exp) begin
                        n_err++;
                        $display("FAIL candidates at (%0d,%0d): got %0d bursts expected %0d", e.x, e.y, nb, nb_exp);
                    end
                end
                last_bursts = bursts;
                got++;
            end
            if (done === 1'b1) dones++;
            if (dones > 0) post++;
            finished = (post > 4);
        end
        n_vec++;
        if (!finished) begin
            n_err++;
            $display("FAIL frame_timeout: got %0d results, %0d done pulses, expected completion", got, dones);
        end
        n_vec++;
        if (got !== N_POS || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL result_count: got %0d expected %0d", got, N_POS);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL done_pulses: got %0d expected 1", dones);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        n_vec++;
        if ({busy, done, bus.rd_en, bus.disp_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, bus.rd_en, bus.disp_valid});
        end
        n_vec++;
        if ({bus.rd_y, bus.rd_left_x, bus.rd_right_x} !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got y=%0d lx=%0d rx=%0d expected 0", bus.rd_y, bus.rd_left_x, bus.rd_right_x);
        end
        n_vec++;
        if ({bus.disp_data, bus.disp_x, bus.disp_y, bus.disp_cost} !== '0) begin
            n_err++;
            $display("FAIL reset_disp: got d=%0d x=%0d y=%0d c=%0d expected 0",
                     bus.disp_data, bus.disp_x, bus.disp_y, bus.disp_cost);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_identical();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                limg[y][x] = x * 7;
                rimg[y][x] = x * 7;
            end
        run_frame(1'b0, 1'b0, fc);
    endtask

    task automatic test_shift3();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) limg[y][x] = int'($urandom_range(0, 255));
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++)
                rimg[y][x] = (x + 3 < IMG_W) ? limg[y][x+3] : int'($urandom_range(0, 255));
        run_frame(1'b1, 1'b0, fc);
    endtask

    task automatic test_tie();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                limg[y][x] = 77;
                rimg[y][x] = 77;
            end
        run_frame(1'b0, 1'b0, fc);
    endtask

    task automatic test_mode();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                limg[y][x] = 10;
                rimg[y][x] = 13;
            end
        run_frame(1'b1, 1'b0, fc);
        n_vec++;
        if (fc !== 12) begin
            n_err++;
            $display("FAIL sad_cost: got %0d expected 12", fc);
        end
        run_frame(1'b0, 1'b0, fc);
        n_vec++;
        if (fc !== 36) begin
            n_err++;
            $display("FAIL ssd_cost: got %0d expected 36", fc);
        end
    endtask

    task automatic test_backpressure();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                limg[y][x] = int'($urandom_range(0, 255));
                rimg[y][x] = int'($urandom_range(0, 255));
            end
        run_frame(1'b0, 1'b1, fc);
    endtask

    task automatic test_reset_mid_fetch();
        int fc;
        for (int y = 0; y < IMG_H; y++)
            for (int x = 0; x < IMG_W; x++) begin
                limg[y][x] = int'($urandom_range(0, 255));
                rimg[y][x] = int'($urandom_range(0, 255));
            end
        @(negedge clk_in);
        start_in = 1'b1;
        mode_in  = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        n_vec++;
        if (bus.rd_en !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_entered: got rd_en=%b expected 1", bus.rd_en);
        end
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, bus.rd_en, bus.disp_valid, bus.rd_y, bus.rd_left_x, bus.rd_right_x,
             bus.disp_data, bus.disp_x, bus.disp_y, bus.disp_cost} !== '0) begin
            n_err++;
            $display("FAIL midfetch_reset: got busy=%b rd_en=%b rd_y=%0d lx=%0d expected all 0",
                     busy, bus.rd_en, bus.rd_y, bus.rd_left_x);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL done_in_reset: got %b expected 0", done);
            end
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        run_frame(1'b0, 1'b0, fc);
    endtask

    initial begin
        bus.disp_ready = 1'b1;
        test_reset();
        test_identical();
        test_shift3();
        test_tie();
        test_mode();
        test_backpressure();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
